count_monitor: RTL and testbench
================================

Name: count_monitor

Overview:
Downstream consumer of the 4-bit up-counter output. It samples the count every clock and classifies each transition:
- wrap-around (max -> 0)
- jump (parallel load or any other discontinuity)
- compare match against a programmable value
Events are queued in a small FIFO and drained over a valid/ready interface. The block also keeps a saturating wrap counter and a sticky overflow flag for status readback.

Parameters:
W, 4, counter width; must match the upstream counter's dout width
DEPTH, 4, event FIFO depth; power of two, >= 2
WC_W, 8, width of the saturating wrap counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
cnt_in  in  W  counter value (upstream dout)
cmp_en  in  1  enable compare-match detection
cmp_val  in  W  compare value
evt_valid  out  1  FIFO head entry valid
evt_ready  in  1  consumer accepts head entry
evt_type  out  2  head entry type: 01 WRAP, 10 JUMP, 11 MATCH-only
evt_match  out  1  head entry also matched cmp_val
evt_value  out  W  cnt_in sampled when the event occurred
overflow  out  1  sticky: an event was dropped because the FIFO was full
wrap_count  out  WC_W  number of wraps seen, saturating at all-ones

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset state:
  - FIFO empty, so evt_valid=0; evt_type, evt_match and evt_value read 0.
  - overflow=0, wrap_count=0.
  - prev register = 0, prev_valid = 0.
- Sampling: cnt_in is sampled on every rising edge with rst=0; prev <= cnt_in and prev_valid <= 1 on that edge.
- Classification is combinational on cnt_in versus prev and uses modulo-2^W arithmetic. It applies only when prev_valid=1.
  - WRAP: prev = 2^W-1 and cnt_in = 0.
  - STEP: cnt_in = prev+1 with no wrap. This is normal counting and is not an event.
  - HOLD: cnt_in = prev. Not an event.
  - JUMP: any other value.
- Match:
  - Condition: cmp_en=1, cnt_in = cmp_val, and either prev_valid=0 or cnt_in != prev.
  - A HOLD at the compare value therefore never re-fires.
- Entry generation: at most one entry per cycle.
  - Type priority is JUMP > WRAP > MATCH-only.
  - evt_match=1 whenever match is true, including on JUMP and WRAP entries.
  - The first sample after reset can produce only a MATCH-only entry.
- Latency: an event on edge k is written on edge k, so evt_valid=1 in the cycle after edge k.
- FIFO: show-ahead, meaning the head entry is driven on the outputs whenever evt_valid=1.
  - Pop when evt_valid & evt_ready.
  - Push with FIFO full and no pop: the entry is dropped and overflow sets. overflow clears only on rst.
  - Push and pop in the same cycle while full: both succeed; occupancy is unchanged and overflow is not set.
  - Push and pop in the same cycle while empty: the push is written; evt_valid rises next cycle. There is no bypass.
- wrap_count increments on every WRAP classification. It counts even when the entry is dropped, and saturates at 2^WC_W-1.
- Reset mid-operation: FIFO contents are discarded, all state returns to reset values, and prev_valid=0. The next sample is a fresh start, so no JUMP is reported for the discontinuity across reset.
- evt_type/evt_value must not change while evt_valid=1 and evt_ready=0.

Decomposition:
- Package count_monitor_pkg holds:
  - EVT_WRAP=2'b01, EVT_JUMP=2'b10, EVT_MATCH=2'b11 constants
  - the event entry typedef {type[1:0], match, value[W-1:0]}
- One sub-module, evt_fifo: a parameterised synchronous show-ahead FIFO (width, depth) with push, pop, full, empty, synchronous active-high reset.
- Classifier, prev register, wrap counter and overflow flag stay in count_monitor.

Test Plan:
- Reset, cmp_en=0, cnt_in counts 0..15,0,1; evt_ready=1.
  - Exactly one entry: type=01, value=0, match=0.
  - evt_valid high the cycle after 0 is sampled; wrap_count=1.
- Counts 2,3, then cnt_in=9 (load), then 10.
  - One entry: type=10, value=9.
  - No entry for 10.
- cmp_en=1, cmp_val=5; counts 4,5,5,5,6.
  - One entry: type=11, match=1, value=5 (no re-fire on HOLD).
  - Same stimulus with a load to 5 gives type=10, match=1.
- DEPTH=4, evt_ready=0, five JUMP events.
  - 4 entries held; overflow=1.
  - Then evt_ready=1 drains exactly the first four values in order.
  - The simultaneous push/pop-at-full case is exercised and no overflow is added.
- FIFO holding 3 entries, rst pulsed for 1 cycle with cnt_in=12, then 13.
  - evt_valid=0 after reset; wrap_count=0; overflow=0.
  - No JUMP for 12 (prev_valid=0) and no event for 13.
- WC_W=2, 5 full wraps with evt_ready=1.
  - wrap_count=3 (saturated); 5 WRAP entries drained.

Source files
------------

// File: rtl/count_monitor_pkg.sv
// Shared event codes, default widths and the event entry layout for count_monitor.
package count_monitor_pkg;

   // Event type codes carried in the entry type field (00 never leaves the FIFO)
   localparam logic [1:0] EVT_NONE  = 2'b00;
   localparam logic [1:0] EVT_WRAP  = 2'b01;
   localparam logic [1:0] EVT_JUMP  = 2'b10;
   localparam logic [1:0] EVT_MATCH = 2'b11;

   // Default counter width, matching the upstream 4-bit counter
   localparam int DEF_W = 4;

   // Event entry as stored in the FIFO for the default counter width
   typedef struct packed {
      logic [1:0]       etype;
      logic             match;
      logic [DEF_W-1:0] value;
   } evt_entry_t;

   // Type selection with JUMP taking priority over WRAP, MATCH-only last
   function automatic logic [1:0] evt_code(input logic jump, input logic wrap);
      if (jump)
         return EVT_JUMP;
      else if (wrap)
         return EVT_WRAP;
      else
         return EVT_MATCH;
   endfunction

endpackage

// File: rtl/count_monitor_evt_fifo.sv
// Synchronous show-ahead FIFO: the head entry is always visible on dout while not empty.
module evt_fifo #(
   parameter int WIDTH = 7,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra bit so full and empty can be told apart
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

   // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Pointer update; reset discards all stored entries
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   // Storage write; contents need no reset since the pointers gate visibility
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr_reg[AW-1:0]] <= din;
   end

   assign dout = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/count_monitor.sv
// Watches an up-counter, classifies each transition (wrap, jump, compare match)
// and queues the resulting events for a valid/ready consumer.
module count_monitor
   import count_monitor_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int DEPTH = 4,
   parameter int WC_W  = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [W-1:0]    cnt_in,
   input  logic            cmp_en,
   input  logic [W-1:0]    cmp_val,
   output logic            evt_valid,
   input  logic            evt_ready,
   output logic [1:0]      evt_type,
   output logic            evt_match,
   output logic [W-1:0]    evt_value,
   output logic            overflow,
   output logic [WC_W-1:0] wrap_count
);

   // Entry layout mirrors evt_entry_t but follows the configured counter width
   typedef struct packed {
      logic [1:0]   etype;
      logic         match;
      logic [W-1:0] value;
   } entry_t;

   localparam int          EW      = $bits(entry_t);
   localparam logic [W-1:0] CNT_MAX = '1;

   logic [W-1:0]    prev_reg;
   logic            prev_valid_reg;
   logic            overflow_reg;
   logic [WC_W-1:0] wrap_count_reg;

   logic            wrap_hit;
   logic            step_hit;
   logic            hold_hit;
   logic            jump_hit;
   logic            match_hit;
   logic            evt_push;
   entry_t          entry_in;
   entry_t          head;
   logic [EW-1:0]   head_bits;
   logic            fifo_full;
   logic            fifo_empty;
   logic            evt_pop;

   // Classify the incoming sample against the previous one (modulo 2^W)
   always_comb begin
      wrap_hit  = 1'b0;
      step_hit  = 1'b0;
      hold_hit  = 1'b0;
      jump_hit  = 1'b0;
      match_hit = cmp_en && (cnt_in == cmp_val) &&
                  (!prev_valid_reg || (cnt_in != prev_reg));
      if (prev_valid_reg) begin
         wrap_hit = (prev_reg == CNT_MAX) && (cnt_in == '0);
         step_hit = (prev_reg != CNT_MAX) && (cnt_in == W'(prev_reg + 1'b1));
         hold_hit = (cnt_in == prev_reg);
         jump_hit = !wrap_hit && !step_hit && !hold_hit;
      end
      evt_push       = jump_hit || wrap_hit || match_hit;
      entry_in.etype = evt_code(jump_hit, wrap_hit);
      entry_in.match = match_hit;
      entry_in.value = cnt_in;
   end

   assign evt_pop = !fifo_empty && evt_ready;

   evt_fifo #(
      .WIDTH(EW),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (evt_push),
      .din  (entry_in),
      .pop  (evt_pop),
      .dout (head_bits),
      .full (fifo_full),
      .empty(fifo_empty)
   );

   assign head = head_bits;

   // Head fields read as zero while the FIFO is empty
   always_comb begin
      evt_valid = !fifo_empty;
      evt_type  = EVT_NONE;
      evt_match = 1'b0;
      evt_value = '0;
      if (!fifo_empty) begin
         evt_type  = head.etype;
         evt_match = head.match;
         evt_value = head.value;
      end
   end

   // Previous-sample register, sticky overflow and saturating wrap counter
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_reg       <= '0;
         prev_valid_reg <= 1'b0;
         overflow_reg   <= 1'b0;
         wrap_count_reg <= '0;
      end else begin
         prev_reg       <= cnt_in;
         prev_valid_reg <= 1'b1;
         if (evt_push && fifo_full && !evt_pop)
            overflow_reg <= 1'b1;
         if (wrap_hit && (wrap_count_reg != '1))
            wrap_count_reg <= wrap_count_reg + 1'b1;
      end
   end

   assign overflow   = overflow_reg;
   assign wrap_count = wrap_count_reg;

endmodule

// File: tb/tb_count_monitor.sv
// Self-checking bench for count_monitor: table-driven vectors plus a scoreboard
// of expected FIFO entries compared as the consumer pops them.
module tb_count_monitor;
   import count_monitor_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] cnt_in = '0;
   logic       cmp_en = 1'b0;
   logic [3:0] cmp_val = '0;
   logic       evt_ready = 1'b0;

   logic       evt_valid, evt_match, overflow;
   logic [1:0] evt_type;
   logic [3:0] evt_value;
   logic [7:0] wrap_count;

   logic       evt_valid2, evt_match2, overflow2;
   logic [1:0] evt_type2;
   logic [3:0] evt_value2;
   logic [1:0] wrap_count2;

   always #5 clk = ~clk;

   count_monitor #(.W(4), .DEPTH(4), .WC_W(8)) dut (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .cmp_en(cmp_en), .cmp_val(cmp_val),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
      .evt_match(evt_match), .evt_value(evt_value), .overflow(overflow),
      .wrap_count(wrap_count)
   );

   // Narrow wrap counter instance sharing the same stimulus, for saturation
   count_monitor #(.W(4), .DEPTH(4), .WC_W(2)) dut_sat (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .cmp_en(cmp_en), .cmp_val(cmp_val),
      .evt_valid(evt_valid2), .evt_ready(evt_ready), .evt_type(evt_type2),
      .evt_match(evt_match2), .evt_value(evt_value2), .overflow(overflow2),
      .wrap_count(wrap_count2)
   );

   typedef struct {
      logic       rst;
      logic [3:0] cnt;
      logic       en;
      logic [3:0] cv;
      logic       rdy;
      logic       ev;
      logic [1:0] etype;
      logic       ematch;
      logic       xvalid;
   } vec_t;

   typedef struct packed {
      logic [1:0] t;
      logic       m;
      logic [3:0] v;
   } exp_t;

   vec_t tbl[$];
   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic [3:0] c, input logic en,
                               input logic [3:0] cv, input logic rdy, input logic ev,
                               input logic [1:0] et, input logic em, input logic xv);
      vec_t v;
      v.rst = r; v.cnt = c; v.en = en; v.cv = cv; v.rdy = rdy;
      v.ev = ev; v.etype = et; v.ematch = em; v.xvalid = xv;
      return v;
   endfunction

   // Drive one vector, queue its expected entry on the sampling edge, check evt_valid after
   task automatic apply(input vec_t v);
      exp_t e;
      rst = v.rst; cnt_in = v.cnt; cmp_en = v.en; cmp_val = v.cv; evt_ready = v.rdy;
      @(posedge clk);
      if (v.ev) begin
         e.t = v.etype; e.m = v.ematch; e.v = v.cnt;
         exp_q.push_back(e);
      end
      @(negedge clk);
      chk($sformatf("evt_valid cnt=%0d", v.cnt), {31'b0, evt_valid}, {31'b0, v.xvalid});
      $display("vec rst=%0b cnt=%0d en=%0b cv=%0d rdy=%0b valid=%0b type=%0d val=%0d ovf=%0b wc=%0d",
               v.rst, v.cnt, v.en, v.cv, v.rdy, evt_valid, evt_type, evt_value, overflow, wrap_count);
      #1;
   endtask

   task automatic run_table();
      foreach (tbl[i]) apply(tbl[i]);
      tbl.delete();
   endtask

   // Consumer side: just before each rising edge, a pop is compared against the scoreboard
   always @(negedge clk) begin
      exp_t e;
      #4;
      if (evt_valid && evt_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_evt: got type=%0d match=%0b value=%0d expected none",
                     evt_type, evt_match, evt_value);
         end else begin
            e = exp_q.pop_front();
            chk("evt_entry", {25'b0, evt_type, evt_match, evt_value}, {25'b0, e});
         end
      end
   end

   initial begin
      // Reset state
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      run_table();
      chk("rst_type", {30'b0, evt_type}, 0);
      chk("rst_match", {31'b0, evt_match}, 0);
      chk("rst_value", {28'b0, evt_value}, 0);
      chk("rst_overflow", {31'b0, overflow}, 0);
      chk("rst_wrap_count", {24'b0, wrap_count}, 0);

      // Plain counting 0..15,0,1: a single WRAP entry
      for (int c = 0; c < 16; c++) tbl.push_back(mk(0, 4'(c), 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, EVT_WRAP, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
      // Load to 9 is a JUMP, 10 afterwards is normal counting
      tbl.push_back(mk(0, 2, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 3, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 9, 0, 0, 1, 1, EVT_JUMP, 0, 1));
      tbl.push_back(mk(0, 10, 0, 0, 1, 0, 0, 0, 0));
      run_table();
      chk("wrap_count_1", {24'b0, wrap_count}, 1);
      chk("wrap_count_sat_1", {30'b0, wrap_count2}, 1);

      // Compare match at 5: fires once, not again on HOLD; load onto 5 gives JUMP+match
      tbl.push_back(mk(0, 4, 1, 5, 1, 1, EVT_JUMP, 0, 1));
      tbl.push_back(mk(0, 5, 1, 5, 1, 1, EVT_MATCH, 1, 1));
      tbl.push_back(mk(0, 5, 1, 5, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 5, 1, 5, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 6, 1, 5, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 3, 1, 5, 1, 1, EVT_JUMP, 0, 1));
      tbl.push_back(mk(0, 5, 1, 5, 1, 1, EVT_JUMP, 1, 1));
      tbl.push_back(mk(0, 5, 1, 5, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 6, 1, 5, 1, 0, 0, 0, 0));
      // WRAP landing on the compare value carries match=1
      tbl.push_back(mk(0, 14, 1, 0, 1, 1, EVT_JUMP, 0, 1));
      tbl.push_back(mk(0, 15, 1, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 1, 1, EVT_WRAP, 1, 1));
      tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 0));
      run_table();
      chk("wrap_count_2", {24'b0, wrap_count}, 2);

      // Fill the FIFO with the consumer stalled
      apply(mk(0, 8, 0, 0, 0, 1, EVT_JUMP, 0, 1));
      apply(mk(0, 3, 0, 0, 0, 1, EVT_JUMP, 0, 1));
      apply(mk(0, 11, 0, 0, 0, 1, EVT_JUMP, 0, 1));
      apply(mk(0, 6, 0, 0, 0, 1, EVT_JUMP, 0, 1));
      chk("stall_head_value", {28'b0, evt_value}, 8);
      chk("stall_head_type", {30'b0, evt_type}, {30'b0, EVT_JUMP});
      // Push and pop together while full: both succeed, no overflow
      apply(mk(0, 14, 0, 0, 1, 1, EVT_JUMP, 0, 1));
      chk("full_push_pop_overflow", {31'b0, overflow}, 0);
      // Full again with the consumer stalled: this entry is dropped
      apply(mk(0, 2, 0, 0, 0, 0, 0, 0, 1));
      chk("overflow_set", {31'b0, overflow}, 1);
      chk("drop_head_value", {28'b0, evt_value}, 3);
      // Drain 3, 11, 6, 14 in order
      tbl.push_back(mk(0, 2, 0, 0, 1, 0, 0, 0, 1));
      tbl.push_back(mk(0, 2, 0, 0, 1, 0, 0, 0, 1));
      tbl.push_back(mk(0, 2, 0, 0, 1, 0, 0, 0, 1));
      tbl.push_back(mk(0, 2, 0, 0, 1, 0, 0, 0, 0));
      run_table();
      chk("drain_scoreboard_empty", exp_q.size(), 0);
      chk("overflow_sticky", {31'b0, overflow}, 1);

      // Reset with three entries held: contents discarded, fresh start at 12
      apply(mk(0, 9, 0, 0, 0, 0, 0, 0, 1));
      apply(mk(0, 4, 0, 0, 0, 0, 0, 0, 1));
      apply(mk(0, 12, 0, 0, 0, 0, 0, 0, 1));
      apply(mk(1, 12, 0, 0, 0, 0, 0, 0, 0));
      chk("midrst_wrap_count", {24'b0, wrap_count}, 0);
      chk("midrst_overflow", {31'b0, overflow}, 0);
      chk("midrst_value", {28'b0, evt_value}, 0);
      apply(mk(0, 12, 0, 0, 1, 0, 0, 0, 0));
      apply(mk(0, 13, 0, 0, 1, 0, 0, 0, 0));

      // Five full wraps: both wrap counters count, the 2-bit one saturates at 3
      tbl.push_back(mk(0, 14, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 15, 0, 0, 1, 0, 0, 0, 0));
      for (int w = 0; w < 5; w++) begin
         tbl.push_back(mk(0, 0, 0, 0, 1, 1, EVT_WRAP, 0, 1));
         for (int c = 1; c < 16; c++) tbl.push_back(mk(0, 4'(c), 0, 0, 1, 0, 0, 0, 0));
      end
      run_table();
      chk("wrap_count_5", {24'b0, wrap_count}, 5);
      chk("wrap_count_saturated", {30'b0, wrap_count2}, 3);
      chk("final_scoreboard_empty", exp_q.size(), 0);
      chk("final_overflow", {31'b0, overflow}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
